// File: rtl/fpu_div_iter.sv
// Iterative radix-2 binary64 divider: one quotient bit per cycle,
// DAZ inputs, flush-to-zero results, packed FPU result format.
module fpu_div_iter #(
    parameter int QBITS = 54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  rmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [67:0] res,
    output logic [4:0]  flags
);

    localparam int RW = QBITS + 1;
    localparam logic [1:0]  PTYPE_DBL = 2'b01;
    localparam logic [62:0] INF_MAG   = 63'h7FF0000000000000;
    localparam logic [62:0] MAX_MAG   = 63'h7FEFFFFFFFFFFFFF;
    localparam logic [63:0] QNAN      = 64'h7FF8000000000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [62:0]        a_q, a_d;
    logic [62:0]        b_q, b_d;
    logic [2:0]         rmode_q, rmode_d;
    logic               sign_q, sign_d;
    logic [52:0]        mb_q, mb_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [QBITS-1:0]   quo_q, quo_d;
    logic signed [12:0] exp_q, exp_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [67:0]        res_q, res_d;
    logic [4:0]         flags_q, flags_d;

    // operand classification
    logic [10:0] a_exp, b_exp;
    logic [51:0] a_frac, b_frac;
    logic a_nan, b_nan, a_snan, b_snan;
    logic a_inf, b_inf, a_zero, b_zero;

    assign a_exp  = a_q[62:52];
    assign b_exp  = b_q[62:52];
    assign a_frac = a_q[51:0];
    assign b_frac = b_q[51:0];
    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_snan = a_nan & ~a_frac[51];
    assign b_snan = b_nan & ~b_frac[51];
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
    assign a_zero = ~(|a_exp);
    assign b_zero = ~(|b_exp);

    logic        is_special;
    logic [63:0] spec_val;
    logic [4:0]  spec_flags;
    logic        inv_case;

    always_comb begin
        is_special = 1'b1;
        spec_val   = '0;
        spec_flags = '0;
        inv_case   = (a_zero & b_zero) | (a_inf & b_inf);
        if (a_nan | b_nan | inv_case) begin
            spec_val   = QNAN;
            spec_flags = {a_snan | b_snan | inv_case, 4'b0000};
        end else if (b_zero) begin
            spec_val   = {sign_q, INF_MAG};
            spec_flags = {1'b0, ~a_inf, 3'b000};
        end else if (a_inf) begin
            spec_val = {sign_q, INF_MAG};
        end else if (a_zero | b_zero | b_inf) begin
            spec_val = {sign_q, 63'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    // significand alignment so the first quotient bit is always 1
    logic [52:0]        ma_n, mb_n;
    logic               ma_lt;
    logic signed [12:0] e_un;

    always_comb begin
        ma_n  = {1'b1, a_frac};
        mb_n  = {1'b1, b_frac};
        ma_lt = ma_n < mb_n;
        e_un  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
              + 13'sd1023;
    end

    logic          q_bit;
    logic [RW-1:0] rem_sub, rem_nxt;

    always_comb begin
        rem_sub = rem_q - {{(RW-53){1'b0}}, mb_q};
        q_bit   = rem_q >= {{(RW-53){1'b0}}, mb_q};
        rem_nxt = q_bit ? rem_sub : rem_q;
    end

    logic               sticky, rnd, lsb, inc, away;
    logic [52:0]        sig;
    logic               carry;
    logic signed [12:0] e_r;
    logic [63:0]        rnd_val;
    logic [4:0]         rnd_flags;

    always_comb begin
        sticky = |rem_q;
        rnd    = quo_q[0];
        lsb    = quo_q[1];
        unique case (rmode_q)
            3'd1:       inc = rnd;
            3'd2, 3'd7: inc = rnd & (sticky | lsb);
            3'd3:       inc = ~sign_q & (rnd | sticky);
            3'd4:       inc = sign_q & (rnd | sticky);
            3'd5:       inc = rnd | sticky;
            default:    inc = 1'b0;
        endcase
        // leading bit is always set, so a wrap to 0 means carry-out
        sig   = quo_q[QBITS-1:1] + {52'd0, inc};
        carry = ~sig[52];
        e_r   = carry ? exp_q + 13'sd1 : exp_q;
        unique case (rmode_q)
            3'd1, 3'd2, 3'd5, 3'd7: away = 1'b1;
            3'd3:                   away = ~sign_q;
            3'd4:                   away = sign_q;
            default:                away = 1'b0;
        endcase
        if (e_r >= 13'sd2047) begin
            rnd_val   = {sign_q, away ? INF_MAG : MAX_MAG};
            rnd_flags = 5'b00101;
        end else if (e_r <= 13'sd0) begin
            rnd_val   = {sign_q, 63'd0};
            rnd_flags = 5'b00011;
        end else begin
            rnd_val   = {sign_q, e_r[10:0], sig[51:0]};
            rnd_flags = {4'b0000, rnd | sticky};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = is_special ? S_DONE : S_ITER;
            S_ITER:   if (cnt_q == 6'd0) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == S_IDLE;
        out_valid = state_q == S_DONE;
        res       = res_q;
        flags     = flags_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        rmode_d = rmode_q;
        sign_d  = sign_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A[62:0];
                    b_d     = B[62:0];
                    rmode_d = rmode;
                    sign_d  = A[63] ^ B[63];
                end
            end
            S_UNPACK: begin
                if (is_special) begin
                    res_d   = {PTYPE_DBL, 2'b00, spec_val};
                    flags_d = spec_flags;
                end else begin
                    mb_d  = mb_n;
                    rem_d = ma_lt ? {1'b0, ma_n, 1'b0} : {2'b00, ma_n};
                    exp_d = ma_lt ? e_un - 13'sd1 : e_un;
                    quo_d = '0;
                    cnt_d = 6'(QBITS - 1);
                end
            end
            S_ITER: begin
                quo_d = {quo_q[QBITS-2:0], q_bit};
                rem_d = rem_nxt << 1;
                cnt_d = cnt_q - 6'd1;
            end
            S_ROUND: begin
                res_d   = {PTYPE_DBL, 2'b00, rnd_val};
                flags_d = rnd_flags;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            rmode_q <= '0;
            sign_q  <= 1'b0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            rmode_q <= rmode_d;
            sign_q  <= sign_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_div_iter.sv
// Bench for fpu_div_iter: arithmetic reference model plus directed
// vectors with hand-computed results, latency and handshake checks.
module tb_fpu_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [2:0]  rmode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [67:0] res;
    logic [4:0]  flags;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_res = '0;
    logic [4:0]  exp_flags = '0;

    always #5 clk = ~clk;

    fpu_div_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .rmode     (rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    task automatic check(input string name, input bit ok,
                         input logic [67:0] act, input logic [67:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: exact long division via wide integer / and %
    function automatic logic [68:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [2:0]  rm);
        logic s, an, bn, asn, bsn, ai, bi, az, bz, inv;
        logic rnd, st, lsb, up, away;
        int ea, eb, e;
        logic [127:0] num, den, q, r;
        logic [63:0] sig;
        s   = a[63] ^ b[63];
        ea  = int'(a[62:52]);
        eb  = int'(b[62:52]);
        an  = (ea == 2047) && (a[51:0] != 0);
        bn  = (eb == 2047) && (b[51:0] != 0);
        asn = an && !a[51];
        bsn = bn && !b[51];
        ai  = (ea == 2047) && (a[51:0] == 0);
        bi  = (eb == 2047) && (b[51:0] == 0);
        az  = ea == 0;
        bz  = eb == 0;
        inv = (az && bz) || (ai && bi);
        if (an || bn || inv)
            return {64'h7FF8000000000000, asn || bsn || inv, 4'b0};
        if (bz)
            return {s, 63'h7FF0000000000000, 1'b0, !ai, 3'b0};
        if (ai)
            return {s, 63'h7FF0000000000000, 5'b0};
        if (az || bi)
            return {s, 63'd0, 5'b0};
        e   = ea - eb + 1023;
        num = {75'd0, 1'b1, a[51:0]};
        den = {75'd0, 1'b1, b[51:0]};
        if (num < den) begin
            num = num << 1;
            e   = e - 1;
        end
        q   = (num << 53) / den;
        r   = (num << 53) % den;
        rnd = q[0];
        lsb = q[1];
        st  = r != 0;
        case (rm)
            3'd1:       up = rnd;
            3'd2, 3'd7: up = rnd && (st || lsb);
            3'd3:       up = !s && (rnd || st);
            3'd4:       up = s && (rnd || st);
            3'd5:       up = rnd || st;
            default:    up = 1'b0;
        endcase
        sig = 64'(q[53:1]) + 64'(up);
        if (sig == 64'h0020000000000000) begin
            sig = 64'h0010000000000000;
            e   = e + 1;
        end
        away = (rm == 1) || (rm == 2) || (rm == 5) || (rm == 7)
            || (rm == 3 && !s) || (rm == 4 && s);
        if (e >= 2047)
            return {s, away ? 63'h7FF0000000000000
                            : 63'h7FEFFFFFFFFFFFFF, 5'b00101};
        if (e <= 0)
            return {s, 63'd0, 5'b00011};
        return {s, 11'(e), sig[51:0], 4'b0, rnd || st};
    endfunction

    // Result must match the model and stay stable while presented
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("res", res[65:0] == {2'b00, exp_res},
                  {2'b00, res[65:0]}, {4'b0, exp_res});
            check("flags", flags == exp_flags,
                  68'(flags), 68'(exp_flags));
            check("busy_in_ready", !in_ready, 68'(in_ready), 68'd0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] rm, input bit lit,
                           input logic [63:0] lr, input logic [4:0] lf,
                           input int lat_req, input int hold);
        logic [68:0] m;
        int lat;
        m = model(a, b, rm);
        if (lit)
            check("model_pin", m == {lr, lf},
                  68'(m), 68'({lr, lf}));
        A = a;
        B = b;
        rmode = rm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_res = m[68:5];
        exp_flags = m[4:0];
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid || lat >= 100) break;
            // stray handshakes while busy must have no effect
            out_ready = lat == 2;
            in_valid = lat == 3;
            A = (lat == 3) ? ~a : a;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        A = a;
        check("latency", lat == lat_req, 68'(lat), 68'(lat_req));
        if (!out_valid) begin
            do_reset();
            return;
        end
        if (lit) begin
            check("res_lit", res[63:0] == lr, 68'(res[63:0]), 68'(lr));
            check("flags_lit", flags == lf, 68'(flags), 68'(lf));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 68'(out_valid), 68'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drop_valid", !out_valid && in_ready,
              68'({out_valid, in_ready}), 68'b01);
    endtask

    task automatic run_abort(input logic [63:0] a, input logic [63:0] b);
        logic [68:0] m;
        m = model(a, b, 3'd2);
        A = a;
        B = b;
        rmode = 3'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_res = m[68:5];
        exp_flags = m[4:0];
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", in_ready && !out_valid,
              68'({in_ready, out_valid}), 68'b10);
        check("abort_res", res == 68'd0 && flags == 5'd0,
              {res[63:0], 4'(flags)}, 68'd0);
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_result", !out_valid && in_ready,
              68'({out_valid, in_ready}), 68'b01);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 68'(in_ready), 68'd1);
        check("rst_valid", !out_valid, 68'(out_valid), 68'd0);
        check("rst_res", res == 68'd0, res, 68'd0);
        check("rst_flags", flags == 5'd0, 68'(flags), 68'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div(64'h4018000000000000, 64'h4000000000000000, 3'd2,
                1, 64'h4008000000000000, 5'b00000, 56, 0);
        run_div(64'h3FF0000000000000, 64'h4008000000000000, 3'd2,
                1, 64'h3FD5555555555555, 5'b00001, 56, 0);
        run_div(64'h3FF0000000000000, 64'h4008000000000000, 3'd3,
                1, 64'h3FD5555555555556, 5'b00001, 56, 10);
        run_div(64'h4014000000000000, 64'h0000000000000000, 3'd2,
                1, 64'h7FF0000000000000, 5'b01000, 1, 0);
        run_div(64'h0000000000000000, 64'h0000000000000000, 3'd2,
                1, 64'h7FF8000000000000, 5'b10000, 1, 0);
        run_div(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 3'd2,
                1, 64'h7FF0000000000000, 5'b00101, 56, 0);
        run_div(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 3'd6,
                1, 64'h7FEFFFFFFFFFFFFF, 5'b00101, 56, 0);
        run_div(64'h7FEFFFFFFFFFFFFF, 64'h3FEFFFFFFFFFFFFF, 3'd4,
                1, 64'h7FEFFFFFFFFFFFFF, 5'b00101, 56, 0);
        run_div(64'h0010000000000000, 64'h4000000000000000, 3'd2,
                1, 64'h0000000000000000, 5'b00011, 56, 0);
        run_div(64'h8010000000000000, 64'h4000000000000000, 3'd3,
                1, 64'h8000000000000000, 5'b00011, 56, 0);
        run_div(64'hBFF0000000000000, 64'h4008000000000000, 3'd4,
                1, 64'hBFD5555555555556, 5'b00001, 56, 0);
        run_div(64'hBFF0000000000000, 64'h4008000000000000, 3'd3,
                1, 64'hBFD5555555555555, 5'b00001, 56, 0);
        run_div(64'h3FF0000000000000, 64'h4008000000000000, 3'd1,
                1, 64'h3FD5555555555555, 5'b00001, 56, 0);
        run_div(64'h3FF0000000000000, 64'h4008000000000000, 3'd5,
                1, 64'h3FD5555555555556, 5'b00001, 56, 0);
        run_div(64'h4000000000000000, 64'h4008000000000000, 3'd7,
                1, 64'h3FE5555555555555, 5'b00001, 56, 0);
        run_div(64'hFFF0000000000000, 64'h4008000000000000, 3'd2,
                1, 64'hFFF0000000000000, 5'b00000, 1, 0);
        run_div(64'h7FF0000000000001, 64'h3FF0000000000000, 3'd2,
                1, 64'h7FF8000000000000, 5'b10000, 1, 0);
        run_div(64'h7FF8000000000001, 64'h3FF0000000000000, 3'd2,
                1, 64'h7FF8000000000000, 5'b00000, 1, 0);
        run_div(64'h4008000000000000, 64'h7FF0000000000000, 3'd2,
                1, 64'h0000000000000000, 5'b00000, 1, 0);
        run_div(64'h0000000000000001, 64'h3FF0000000000000, 3'd2,
                1, 64'h0000000000000000, 5'b00000, 1, 0);
        run_div(64'h3FF0000000000000, 64'h800FFFFFFFFFFFFF, 3'd2,
                1, 64'hFFF0000000000000, 5'b01000, 1, 0);
        run_div(64'h4024000000000000, 64'h401C000000000000, 3'd2,
                0, 64'd0, 5'd0, 56, 0);
        run_div(64'h3FF0000000000000, 64'h401C000000000000, 3'd0,
                0, 64'd0, 5'd0, 56, 0);
        run_div(64'hC05EDD2F1A9FBE77, 64'h3FB999999999999A, 3'd5,
                0, 64'd0, 5'd0, 56, 2);

        run_abort(64'h3FF0000000000000, 64'h4008000000000000);
        run_div(64'h4018000000000000, 64'h4000000000000000, 3'd2,
                1, 64'h4008000000000000, 5'b00000, 56, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
